// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared types and width constants for the memory access
//               stage (state encoding, operation encoding, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Controller-facing request/response signals and RAM-facing
//               bus of the memory access stage. The slave modport is the
//               access unit's view; master is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int AW = mem_if_pkg::ADDR_W_DEF,
  parameter int DW = mem_if_pkg::DATA_W_DEF
);

  // controller side
  logic          req_read;
  logic          req_write;
  logic          sel_src_pc;
  logic          sel_src_tr;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] tr_addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  logic          busy;
  logic          req_err;

  // RAM side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_read, req_write, sel_src_pc, sel_src_tr,
    input  pc_addr, tr_addr, wdata, mem_rdata,
    output rdata, done, busy, req_err,
    output mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output req_read, req_write, sel_src_pc, sel_src_tr,
    output pc_addr, tr_addr, wdata, mem_rdata,
    input  rdata, done, busy, req_err,
    input  mem_addr, mem_wdata, mem_re, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Wait-state down counter. Loads a start value, decrements
//               while enabled and non-zero, flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter
  import mem_if_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_load,
  input  wire logic                  i_en,
  input  wire logic [WAIT_CNT_W-1:0] i_load_val,
  output logic                       o_zero
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // load has priority over decrement; counting stops at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory access stage. Accepts a single read or write request
//               from the controller, muxes the PC/TR address, sequences one
//               fixed-latency RAM access and returns a one-cycle done pulse.
//               Optional one-entry read buffer enabled by the macro
//               MEMIF_FETCH_BUF_EN (read hits complete without RAM access).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int AW          = ADDR_W_DEF,
  parameter int DW          = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_access_unit_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_t        r_state;
  state_t        w_next;
  op_t           r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_legal;
  logic          w_illegal;
  logic [AW-1:0] w_addr_mux;
  logic          w_hit;
  logic          w_accept;
  logic          w_load;
  logic          w_en;
  logic          w_zero;
  logic          w_capture;
  logic          w_wr_strobe;
  logic          w_busy;
  logic          w_done;
  logic          w_req_err;
  logic          w_mem_re;

  // Request decode: exactly one operation and exactly one address source.
  assign w_legal    = (bus.req_read ^ bus.req_write) & (bus.sel_src_pc ^ bus.sel_src_tr);
  assign w_illegal  = (bus.req_read | bus.req_write) & ~w_legal;
  assign w_addr_mux = bus.sel_src_pc ? bus.pc_addr : bus.tr_addr;
  assign w_accept   = (r_state == IDLE) && w_legal;

`ifdef MEMIF_FETCH_BUF_EN
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_tag;
  logic [DW-1:0] r_buf_data;

  assign w_hit = r_buf_vld && bus.req_read && w_legal && (w_addr_mux == r_buf_tag);

  // read buffer: refilled by every RAM read, kept coherent with matching writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= '0;
      r_buf_data <= '0;
    end else if (w_capture) begin
      r_buf_vld  <= 1'b1;
      r_buf_tag  <= r_addr;
      r_buf_data <= bus.mem_rdata;
    end else if (w_wr_strobe && r_buf_vld && (r_addr == r_buf_tag)) begin
      r_buf_data <= r_wdata;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  mem_wait_counter u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (c_WAIT_LOAD),
    .o_zero     (w_zero)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic and status/strobe outputs
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_capture   = 1'b0;
    w_wr_strobe = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_req_err   = 1'b0;
    w_mem_re    = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_err = w_illegal;
        if (w_legal) begin
          if (w_hit) begin
            w_next = DONE;
          end else begin
            w_next = ACCESS;
            w_load = 1'b1;
          end
        end
      end
      ACCESS: begin
        w_busy      = 1'b1;
        w_mem_re    = (r_op == OP_READ);
        // a store strobes only on the final wait cycle: one strobe per write
        w_wr_strobe = (r_op == OP_WRITE) && w_zero;
        if (w_zero) begin
          w_next    = DONE;
          w_capture = (r_op == OP_READ);
        end else begin
          w_en = 1'b1;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // latch operation, address and store data on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_op    <= bus.req_write ? OP_WRITE : OP_READ;
      r_addr  <= w_addr_mux;
      r_wdata <= bus.wdata;
    end
  end

  // read data register: holds until the next completed read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= bus.mem_rdata;
`ifdef MEMIF_FETCH_BUF_EN
    end else if (w_accept && w_hit) begin
      r_rdata <= r_buf_data;
`endif
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.done      = w_done;
  assign bus.busy      = w_busy;
  assign bus.req_err   = w_req_err;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_re    = w_mem_re;
  assign bus.mem_we    = w_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: table of request
//               patterns plus hand-written read/write/reset/buffer sequences.
//               Buffer expectations follow MEMIF_FETCH_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_if_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int WS = 2;

  typedef struct {
    logic          rd;
    logic          wr;
    logic          spc;
    logic          str;
    logic [AW-1:0] pc;
    logic [AW-1:0] tr;
    logic [DW-1:0] wd;
    logic [DW-1:0] mrd;
    logic          err;
    int            lat;
    int            re_n;
    int            we_n;
    logic [DW-1:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_unit #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req();
    bus.req_read   = 1'b0;
    bus.req_write  = 1'b0;
    bus.sel_src_pc = 1'b0;
    bus.sel_src_tr = 1'b0;
  endtask

  // Issues a request from IDLE and follows it to done (bounded), recording
  // latency, strobe counts and address stability.
  task automatic do_access(
    input  logic rd, input logic wr, input logic spc, input logic str,
    input  logic [AW-1:0] pc, input logic [AW-1:0] tr,
    input  logic [DW-1:0] wd, input logic [DW-1:0] mrd,
    input  bit mid_en, input logic [AW-1:0] mid_pc,
    output int lat, output int re_n, output int we_n, output int addr_bad,
    output logic err0, output logic busy_done, output logic [DW-1:0] rd_done,
    output logic [AW-1:0] we_addr, output logic [DW-1:0] we_data);
    logic [AW-1:0] exp_addr;
    lat = 0; re_n = 0; we_n = 0; addr_bad = 0;
    busy_done = 1'b1; rd_done = '0; we_addr = '0; we_data = '0;
    bus.req_read = rd; bus.req_write = wr;
    bus.sel_src_pc = spc; bus.sel_src_tr = str;
    bus.pc_addr = pc; bus.tr_addr = tr; bus.wdata = wd; bus.mem_rdata = mrd;
    exp_addr = spc ? pc : tr;
    #1;
    err0 = bus.req_err;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (mid_en && c == 2) begin
        bus.pc_addr = mid_pc;
        bus.wdata   = ~wd;
        #1;
      end
      if (bus.mem_re) re_n++;
      if (bus.mem_we) begin
        we_n++;
        we_addr = bus.mem_addr;
        we_data = bus.mem_wdata;
      end
      if (bus.busy && bus.mem_addr !== exp_addr) addr_bad++;
      if (bus.done) begin
        lat = c;
        busy_done = bus.busy;
        rd_done = bus.rdata;
        break;
      end
    end
    drop_req();
    step();
  endtask

  vec_t          tbl [10];
  int            lat, re_n, we_n, abad;
  logic          err0, bdone;
  logic [DW-1:0] rdd, wdat;
  logic [AW-1:0] wadr;

  initial begin
    rst = 1'b1;
    drop_req();
    bus.pc_addr = '0; bus.tr_addr = '0; bus.wdata = '0; bus.mem_rdata = '0;

    //          rd   wr   spc  str  pc        tr        wd     mrd    err  lat re we rdata
    tbl[0] = '{1'b1,1'b0,1'b1,1'b0,13'h0100,13'h0000,8'h00,8'h11,1'b0, 4, 3, 0, 8'h11};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,13'h0101,13'h0000,8'h00,8'hFF,1'b1, 0, 0, 0, 8'h11};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b1,13'h0000,13'h0200,8'h00,8'h22,1'b0, 4, 3, 0, 8'h22};
    tbl[3] = '{1'b1,1'b0,1'b1,1'b1,13'h0102,13'h0202,8'h00,8'hFF,1'b1, 0, 0, 0, 8'h22};
    tbl[4] = '{1'b0,1'b1,1'b1,1'b0,13'h0300,13'h0000,8'h33,8'hEE,1'b0, 4, 0, 1, 8'h22};
    tbl[5] = '{1'b1,1'b1,1'b1,1'b0,13'h0103,13'h0000,8'h55,8'hFF,1'b1, 0, 0, 0, 8'h22};
    tbl[6] = '{1'b0,1'b1,1'b0,1'b0,13'h0104,13'h0000,8'h56,8'hFF,1'b1, 0, 0, 0, 8'h22};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,13'h0105,13'h0000,8'h00,8'hFF,1'b0, 0, 0, 0, 8'h22};
    tbl[8] = '{1'b0,1'b0,1'b1,1'b0,13'h0106,13'h0000,8'h00,8'hFF,1'b0, 0, 0, 0, 8'h22};
    tbl[9] = '{1'b0,1'b1,1'b0,1'b1,13'h0000,13'h0400,8'h44,8'hEE,1'b0, 4, 0, 1, 8'h22};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // reset values
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_flags", {27'h0, bus.done, bus.busy, bus.req_err, bus.mem_re, bus.mem_we}, 32'h0);

    // request decode table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].lat == 0) begin
        bus.req_read = tbl[i].rd; bus.req_write = tbl[i].wr;
        bus.sel_src_pc = tbl[i].spc; bus.sel_src_tr = tbl[i].str;
        bus.pc_addr = tbl[i].pc; bus.tr_addr = tbl[i].tr;
        bus.wdata = tbl[i].wd; bus.mem_rdata = tbl[i].mrd;
        #1;
        chk($sformatf("v%0d_req_err", i), 32'(bus.req_err), 32'(tbl[i].err));
        drop_req();
        step();
        chk($sformatf("v%0d_idle", i), {29'h0, bus.busy, bus.mem_re, bus.mem_we}, 32'h0);
        chk($sformatf("v%0d_err_pulse", i), 32'(bus.req_err), 32'h0);
        chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rdata));
      end else begin
        do_access(tbl[i].rd, tbl[i].wr, tbl[i].spc, tbl[i].str, tbl[i].pc, tbl[i].tr,
                  tbl[i].wd, tbl[i].mrd, 1'b0, '0,
                  lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
        chk($sformatf("v%0d_req_err", i), 32'(err0), 32'(tbl[i].err));
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        chk($sformatf("v%0d_re_cycles", i), 32'(re_n), 32'(tbl[i].re_n));
        chk($sformatf("v%0d_we_cycles", i), 32'(we_n), 32'(tbl[i].we_n));
        chk($sformatf("v%0d_rdata", i), 32'(rdd), 32'(tbl[i].rdata));
        chk($sformatf("v%0d_addr_stable", i), 32'(abad), 32'h0);
      end
    end

    // read at PC 0x0010, PC changes mid-access
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 13'h0010, 13'h0000, 8'h00, 8'hA5, 1'b1, 13'h0020,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_re_cycles", 32'(re_n), 32'd3);
    chk("rd_we_cycles", 32'(we_n), 32'd0);
    chk("rd_addr_stable", 32'(abad), 32'd0);
    chk("rd_busy_in_done", 32'(bdone), 32'd0);
    chk("rd_rdata", 32'(rdd), 32'hA5);

    // write at TR 0x1F00, store data changes mid-access
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 13'h0000, 13'h1F00, 8'h3C, 8'h99, 1'b1, 13'h0020,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_we_cycles", 32'(we_n), 32'd1);
    chk("wr_re_cycles", 32'(re_n), 32'd0);
    chk("wr_we_addr", 32'(wadr), 32'h1F00);
    chk("wr_we_data", 32'(wdat), 32'h3C);
    chk("wr_rdata_kept", 32'(rdd), 32'hA5);

    // reset during the strobe cycle of a write
    bus.req_write = 1'b1; bus.sel_src_tr = 1'b1; bus.tr_addr = 13'h0555; bus.wdata = 8'h66;
    repeat (3) step();
    chk("mid_rst_pre_we", 32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("mid_rst_rdata", 32'(bus.rdata), 32'h0);
    drop_req();
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mid_rst_no_done", 32'(bus.done), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 13'h0123, 13'h0000, 8'h00, 8'hC3, 1'b0, '0,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_rdata", 32'(rdd), 32'hC3);

    // back-to-back reads of the same address, then write/read of it
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 13'h0010, 13'h0000, 8'h00, 8'h5A, 1'b0, '0,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
    chk("buf_fill_latency", 32'(lat), 32'd4);
    chk("buf_fill_rdata", 32'(rdd), 32'h5A);
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 13'h0010, 13'h0000, 8'h00, 8'h99, 1'b0, '0,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
`ifdef MEMIF_FETCH_BUF_EN
    chk("hit_latency", 32'(lat), 32'd1);
    chk("hit_re_cycles", 32'(re_n), 32'd0);
    chk("hit_rdata", 32'(rdd), 32'h5A);
`else
    chk("reread_latency", 32'(lat), 32'd4);
    chk("reread_re_cycles", 32'(re_n), 32'd3);
    chk("reread_rdata", 32'(rdd), 32'h99);
`endif
    do_access(1'b0, 1'b1, 1'b1, 1'b0, 13'h0010, 13'h0000, 8'h77, 8'h00, 1'b0, '0,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
    chk("buf_wr_we_cycles", 32'(we_n), 32'd1);
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 13'h0010, 13'h0000, 8'h00, 8'h00, 1'b0, '0,
              lat, re_n, we_n, abad, err0, bdone, rdd, wadr, wdat);
`ifdef MEMIF_FETCH_BUF_EN
    chk("hit_after_wr_latency", 32'(lat), 32'd1);
    chk("hit_after_wr_rdata", 32'(rdd), 32'h77);
`else
    chk("rd_after_wr_latency", 32'(lat), 32'd4);
    chk("rd_after_wr_rdata", 32'(rdd), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
